// File: rtl/lbm_wall_addr_gen.sv
// Perimeter-cell address sequencer for the LBM bounce-back/lid phase.
// Walks lid, bottom, left and right walls once per start, one cell per accepted handshake.
module lbm_wall_addr_gen #(
    parameter int GRID_X        = 16,
    parameter int GRID_Y        = 16,
    parameter int GRID_DIM      = GRID_X * GRID_Y,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM),
    parameter int COUNT_WIDTH   = $clog2(2 * (GRID_X + GRID_Y))
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     start,
    input  logic                     bc_addr_iter_en,
    output logic [ADDRESS_WIDTH-1:0] wall_address,
    output logic                     wall_valid,
    output logic                     LID,
    output logic                     BOTTOM_WALL,
    output logic                     LEFT_WALL,
    output logic                     RIGHT_WALL,
    output logic [COUNT_WIDTH-1:0]   wall_count,
    output logic                     done
);

    localparam int IDX_W = $clog2(GRID_X > GRID_Y ? GRID_X : GRID_Y);

    // Terminal index of each segment; corners belong to bottom/left/right, never the lid.
    localparam logic [IDX_W-1:0] LID_LAST    = IDX_W'(GRID_X - 3);
    localparam logic [IDX_W-1:0] BOTTOM_LAST = IDX_W'(GRID_X - 1);
    localparam logic [IDX_W-1:0] SIDE_LAST   = IDX_W'(GRID_Y - 2);

    localparam logic [ADDRESS_WIDTH-1:0] LID_FIRST    = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] BOTTOM_FIRST = ADDRESS_WIDTH'((GRID_Y - 1) * GRID_X);
    localparam logic [ADDRESS_WIDTH-1:0] LEFT_FIRST   = '0;
    localparam logic [ADDRESS_WIDTH-1:0] RIGHT_FIRST  = ADDRESS_WIDTH'(GRID_X - 1);
    localparam logic [ADDRESS_WIDTH-1:0] STEP_COL     = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] STEP_ROW     = ADDRESS_WIDTH'(GRID_X);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LID,
        S_BOTTOM,
        S_LEFT,
        S_RIGHT,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] seg_idx_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            seg_idx_reg  <= '0;
            wall_address <= '0;
            wall_valid   <= 1'b0;
            LID          <= 1'b0;
            BOTTOM_WALL  <= 1'b0;
            LEFT_WALL    <= 1'b0;
            RIGHT_WALL   <= 1'b0;
            wall_count   <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_LID;
                        seg_idx_reg  <= '0;
                        wall_address <= LID_FIRST;
                        wall_valid   <= 1'b1;
                        LID          <= 1'b1;
                        wall_count   <= '0;
                    end
                end
                S_LID: begin
                    if (bc_addr_iter_en) begin
                        wall_count <= wall_count + COUNT_WIDTH'(1);
                        if (seg_idx_reg == LID_LAST) begin
                            state_reg    <= S_BOTTOM;
                            seg_idx_reg  <= '0;
                            wall_address <= BOTTOM_FIRST;
                            LID          <= 1'b0;
                            BOTTOM_WALL  <= 1'b1;
                        end else begin
                            seg_idx_reg  <= seg_idx_reg + IDX_W'(1);
                            wall_address <= wall_address + STEP_COL;
                        end
                    end
                end
                S_BOTTOM: begin
                    if (bc_addr_iter_en) begin
                        wall_count <= wall_count + COUNT_WIDTH'(1);
                        if (seg_idx_reg == BOTTOM_LAST) begin
                            state_reg    <= S_LEFT;
                            seg_idx_reg  <= '0;
                            wall_address <= LEFT_FIRST;
                            BOTTOM_WALL  <= 1'b0;
                            LEFT_WALL    <= 1'b1;
                        end else begin
                            seg_idx_reg  <= seg_idx_reg + IDX_W'(1);
                            wall_address <= wall_address + STEP_COL;
                        end
                    end
                end
                S_LEFT: begin
                    if (bc_addr_iter_en) begin
                        wall_count <= wall_count + COUNT_WIDTH'(1);
                        if (seg_idx_reg == SIDE_LAST) begin
                            state_reg    <= S_RIGHT;
                            seg_idx_reg  <= '0;
                            wall_address <= RIGHT_FIRST;
                            LEFT_WALL    <= 1'b0;
                            RIGHT_WALL   <= 1'b1;
                        end else begin
                            seg_idx_reg  <= seg_idx_reg + IDX_W'(1);
                            wall_address <= wall_address + STEP_ROW;
                        end
                    end
                end
                S_RIGHT: begin
                    if (bc_addr_iter_en) begin
                        wall_count <= wall_count + COUNT_WIDTH'(1);
                        if (seg_idx_reg == SIDE_LAST) begin
                            state_reg    <= S_DONE;
                            seg_idx_reg  <= '0;
                            wall_address <= '0;
                            wall_valid   <= 1'b0;
                            RIGHT_WALL   <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            seg_idx_reg  <= seg_idx_reg + IDX_W'(1);
                            wall_address <= wall_address + STEP_ROW;
                        end
                    end
                end
                S_DONE: begin
                    // wall_count keeps the final total until the next start
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbm_wall_addr_gen.sv
// Scoreboard bench for lbm_wall_addr_gen: expected perimeter order is queued at start
// and compared against every presented address, with flag, count and done timing checks.
module tb_lbm_wall_addr_gen;

    localparam int GX = 16;
    localparam int GY = 16;
    localparam int GD = GX * GY;
    localparam int AW = $clog2(GD);
    localparam int CW = $clog2(2 * (GX + GY));
    localparam int NCELLS = 2 * GX + 2 * GY - 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          bc_addr_iter_en;
    logic [AW-1:0] wall_address;
    logic          wall_valid;
    logic          lid;
    logic          bottom_wall;
    logic          left_wall;
    logic          right_wall;
    logic [CW-1:0] wall_count;
    logic          done;
    logic [3:0]    flags;

    assign flags = {lid, bottom_wall, left_wall, right_wall};

    typedef struct {
        int unsigned addr;
        int unsigned flags;
    } exp_t;

    exp_t sb[$];
    int   tests;
    int   failures;

    lbm_wall_addr_gen #(
        .GRID_X(GX),
        .GRID_Y(GY),
        .GRID_DIM(GD),
        .ADDRESS_WIDTH(AW),
        .COUNT_WIDTH(CW)
    ) dut (
        .Clk(clk),
        .Reset(rst),
        .start(start),
        .bc_addr_iter_en(bc_addr_iter_en),
        .wall_address(wall_address),
        .wall_valid(wall_valid),
        .LID(lid),
        .BOTTOM_WALL(bottom_wall),
        .LEFT_WALL(left_wall),
        .RIGHT_WALL(right_wall),
        .wall_count(wall_count),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
        tests++;
        if (obs !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_walk();
        exp_t e;
        sb.delete();
        for (int c = 1; c <= GX - 2; c++) begin
            e.addr = c; e.flags = 4'b1000; sb.push_back(e);
        end
        for (int c = 0; c < GX; c++) begin
            e.addr = (GY - 1) * GX + c; e.flags = 4'b0100; sb.push_back(e);
        end
        for (int r = 0; r < GY - 1; r++) begin
            e.addr = r * GX; e.flags = 4'b0010; sb.push_back(e);
        end
        for (int r = 0; r < GY - 1; r++) begin
            e.addr = r * GX + GX - 1; e.flags = 4'b0001; sb.push_back(e);
        end
        $display("[TB] walk queued: %0d expected addresses", sb.size());
    endtask

    task automatic check_idle_outputs(input string tag, input int unsigned exp_count);
        check({tag, "_addr"}, wall_address, 0);
        check({tag, "_valid"}, wall_valid, 0);
        check({tag, "_flags"}, flags, 0);
        check({tag, "_count"}, wall_count, exp_count);
        check({tag, "_done"}, done, 0);
    endtask

    // One full walk from IDLE; call and return at a negedge.
    task automatic run_walk(input string name, input bit toggle_en, input bit restart_mid);
        int        cycles;
        int        accepted;
        int        a;
        int        row;
        int        col;
        bit        en_next;
        bit        restarted;
        bit        got_done;
        bit [GD-1:0] hit;
        exp_t      e;
        hit = '0; accepted = 0; restarted = 0; got_done = 0; cycles = 0;
        push_walk();
        start = 1'b1;
        bc_addr_iter_en = 1'b1;   // en alongside start in IDLE must be ignored
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cycles < 400) begin
            if (done) begin
                got_done = 1'b1;
                check("done_latency", cycles, toggle_en ? 2 * NCELLS - 1 : NCELLS);
                check("final_count", wall_count, NCELLS);
                check("done_valid", wall_valid, 0);
                check("done_flags", flags, 0);
                check("sb_empty", sb.size(), 0);
                check("coverage", $countones(hit), NCELLS);
                $display("[TB] %s: done after %0d cycles, count=%0d", name, cycles, wall_count);
                start = restart_mid;  // start in the done cycle must be ignored
            end else begin
                check("valid_mid_walk", wall_valid, 1);
                if (sb.size() == 0) begin
                    check("sb_underflow", wall_address, 0);
                    e.addr = 0; e.flags = 0;
                end else begin
                    e = sb[0];
                end
                a   = int'(wall_address);
                row = a / GX;
                col = a % GX;
                check("addr", wall_address, e.addr);
                check("flags", flags, e.flags);
                check("onehot", $countones(flags), 1);
                check("count", wall_count, accepted);
                check("perimeter", (row == 0 || row == GY - 1 || col == 0 || col == GX - 1), 1);
                en_next = toggle_en ? (cycles % 2 == 0) : 1'b1;
                if (restart_mid && bottom_wall && !restarted) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end else begin
                    start = 1'b0;
                end
                bc_addr_iter_en = en_next;
                if (en_next) begin
                    check("no_repeat", hit[a], 0);
                    hit[a] = 1'b1;
                    if (sb.size() != 0) void'(sb.pop_front());
                    accepted++;
                    $display("[TB] %s: accept addr=%0d flags=%b count=%0d", name, a, flags, wall_count);
                end
            end
            @(negedge clk);
            cycles++;
        end
        check("walk_done", got_done, 1);
        start = 1'b0;
        bc_addr_iter_en = 1'b1;
        check_idle_outputs("post_done", NCELLS);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stay_idle_valid", wall_valid, 0);
            check("no_second_done", done, 0);
        end
        check("count_held", wall_count, NCELLS);
        bc_addr_iter_en = 1'b0;
    endtask

    initial begin
        bit found;
        tests = 0; failures = 0;
        rst = 1'b1; start = 1'b0; bc_addr_iter_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset", 0);

        // mid-sim asynchronous reset, then en pulses in IDLE must do nothing
        #2 rst = 1'b1;
        #1 check_idle_outputs("async_reset", 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bc_addr_iter_en = (i % 2 == 0);
            @(negedge clk);
            check("idle_en_valid", wall_valid, 0);
            check("idle_en_count", wall_count, 0);
        end
        bc_addr_iter_en = 1'b0;

        run_walk("held_en", 1'b0, 1'b0);
        run_walk("toggled_en", 1'b1, 1'b0);
        run_walk("restart_mid", 1'b0, 1'b1);

        // reset while presenting address 32 on the left wall
        push_walk();
        start = 1'b1; bc_addr_iter_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (wall_valid && wall_address == AW'(32)) found = 1'b1;
            else @(negedge clk);
        end
        check("reach_addr32", found, 1);
        check("addr32_left", flags, 4'b0010);
        #1 rst = 1'b1;
        #1 check_idle_outputs("reset_mid_walk", 0);
        @(negedge clk);
        check("no_done_in_reset", done, 0);
        rst = 1'b0;
        bc_addr_iter_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_mid_reset", 0);
        run_walk("after_reset", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
